// File: rtl/threadbrain_pkg.sv
// Shared types and widths for the core-to-memory path and the register-file
// writeback stage.
package threadbrain_pkg;

  localparam int WORD_W   = 16;
  localparam int RF_VAL_W = WORD_W;
  localparam int RF_PTR_W = WORD_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Core-id width; a single core still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible core at or above the
// pointer, wrapping modulo NCORES (not necessarily a power of two).
module rr_pick
  import threadbrain_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int ID_W   = id_width(NCORES)
) (
  input  logic [NCORES-1:0] i_eligible,
  input  logic [ID_W-1:0]   i_rr_ptr,
  output logic              o_found,
  output logic [ID_W-1:0]   o_id
);

  always_comb begin : pick
    int w_idx;
    w_idx   = 0;
    o_found = 1'b0;
    o_id    = '0;
    // Scan from farthest to nearest so the nearest eligible core wins.
    for (int k = NCORES - 1; k >= 0; k--) begin
      w_idx = int'(i_rr_ptr) + k;
      if (w_idx >= NCORES) w_idx = w_idx - NCORES;
      for (int j = 0; j < NCORES; j++) begin
        if (j == w_idx && i_eligible[j]) begin
          o_found = 1'b1;
          o_id    = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NCORES cores;
// completed reads are forwarded to the register-file writeback stage.
module mem_arbiter
  import threadbrain_pkg::*;
#(
  parameter int NCORES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCORES-1:0]        req,
  input  logic [NCORES-1:0]        we,
  input  logic [NCORES*WORD_W-1:0] addr,
  input  logic [NCORES*WORD_W-1:0] wdata,
  output logic [NCORES-1:0]        done,
  output logic                     mem_valid,
  output logic                     mem_we,
  output logic [WORD_W-1:0]        mem_addr,
  output logic [WORD_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [WORD_W-1:0]        mem_rdata,
  output logic                     wb_en,
  output logic [RF_VAL_W-1:0]      wb_val,
  output logic [RF_PTR_W-1:0]      wb_ptr
);

  localparam int ID_W = id_width(NCORES);

  arb_state_e          r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  mem_req_t            r_req;
  logic                r_mem_valid;
  logic [NCORES-1:0]   r_done;
  logic                r_wb_en;
  logic [RF_VAL_W-1:0] r_wb_val;
  logic [RF_PTR_W-1:0] r_wb_ptr;

  logic [NCORES-1:0]   w_eligible;
  logic                w_found;
  logic [ID_W-1:0]     w_pick_id;
  logic [ID_W-1:0]     w_next_ptr;
  logic [NCORES-1:0]   w_id_onehot;
  mem_req_t            w_sel_req;

  // The core being completed this cycle is not re-granted until next cycle.
  assign w_eligible = req & ~r_done;

  rr_pick #(.NCORES(NCORES), .ID_W(ID_W)) u_pick (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_found    (w_found),
    .o_id       (w_pick_id)
  );

  assign w_next_ptr = (r_id == ID_W'(NCORES - 1)) ? '0 : r_id + ID_W'(1);

  always_comb begin
    w_id_onehot = '0;
    w_sel_req   = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (ID_W'(i) == r_id) w_id_onehot[i] = 1'b1;
      if (ID_W'(i) == w_pick_id) begin
        w_sel_req.we    = we[i];
        w_sel_req.addr  = addr[i*WORD_W +: WORD_W];
        w_sel_req.wdata = wdata[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_req       <= '0;
      r_mem_valid <= 1'b0;
      r_done      <= '0;
      r_wb_en     <= 1'b0;
      r_wb_val    <= '0;
      r_wb_ptr    <= '0;
    end else begin
      r_done  <= '0;
      r_wb_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_id        <= w_pick_id;
            r_req       <= w_sel_req;
            r_mem_valid <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            if (r_req.we) begin
              r_done   <= w_id_onehot;
              r_rr_ptr <= w_next_ptr;
              r_state  <= IDLE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_wb_en  <= 1'b1;
            r_wb_val <= mem_rdata;
            r_wb_ptr <= r_req.addr;
            r_done   <= w_id_onehot;
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign mem_valid = r_mem_valid;
  assign mem_we    = r_req.we;
  assign mem_addr  = r_req.addr;
  assign mem_wdata = r_req.wdata;
  assign wb_en     = r_wb_en;
  assign wb_val    = r_wb_val;
  assign wb_ptr    = r_wb_ptr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table with a scoreboard queue, plus
// hand-written multi-cycle sequences and a 3-core instance for wrap.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req = '0, we = '0, done;
  logic [63:0] addr = '0, wdata = '0;
  logic        mem_valid, mem_we, mem_ready = 1'b0, mem_rvalid = 1'b0, wb_en;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0, wb_val, wb_ptr;

  logic [2:0]  req3 = '0, we3 = 3'b111, done3;
  logic [47:0] addr3 = 48'h0003_0002_0001, wdata3 = '0;
  logic        mem_valid3, mem_we3, mem_ready3 = 1'b0, wb_en3;
  logic [15:0] mem_addr3, mem_wdata3, wb_val3, wb_ptr3;

  mem_arbiter #(.NCORES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_val(wb_val), .wb_ptr(wb_ptr)
  );

  mem_arbiter #(.NCORES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .done(done3), .mem_valid(mem_valid3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_ready(mem_ready3), .mem_rvalid(1'b0),
    .mem_rdata(16'h0000), .wb_en(wb_en3), .wb_val(wb_val3), .wb_ptr(wb_ptr3)
  );

  typedef struct {
    int         core;
    bit         wr;
    logic [15:0] a, d;
    int         rdy, rv;
    logic [15:0] rdata;
    logic [3:0] exp_done;
    bit         exp_wb;
    logic [15:0] exp_val, exp_ptr;
    int         exp_cyc;
  } vec_t;

  vec_t vt[6];
  vec_t sb_q[$];
  int   n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single transaction; the memory side also injects stray rvalid in REQ
  // and stray ready in WAIT, both of which must be ignored.
  task automatic run_vec(input vec_t v, input int n);
    vec_t e;
    int   rdy_cyc, rv_cyc;
    bit   got;
    rdy_cyc = 1 + v.rdy;
    rv_cyc  = v.wr ? -1 : rdy_cyc + v.rv;
    req[v.core] = 1'b1;
    we[v.core]  = v.wr;
    addr[v.core*16 +: 16]  = v.a;
    wdata[v.core*16 +: 16] = v.d;
    sb_q.push_back(v);
    got = 1'b0;
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        got = 1'b1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d done", n), done, e.exp_done);
        chk($sformatf("v%0d latency", n), cyc, e.exp_cyc);
        chk($sformatf("v%0d wb_en", n), wb_en, e.exp_wb);
        chk($sformatf("v%0d wb_val", n), wb_val, e.exp_val);
        chk($sformatf("v%0d wb_ptr", n), wb_ptr, e.exp_ptr);
        req[v.core] = 1'b0;
      end else begin
        chk($sformatf("v%0d mem_valid c%0d", n, cyc), mem_valid, cyc <= rdy_cyc);
        chk($sformatf("v%0d early wb_en c%0d", n, cyc), wb_en, 1'b0);
        if (cyc <= rdy_cyc) begin
          chk($sformatf("v%0d mem_addr", n), mem_addr, v.a);
          chk($sformatf("v%0d mem_we", n), mem_we, v.wr);
          if (v.wr) chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.d);
        end
      end
      mem_ready  = (cyc == rdy_cyc) || (!v.wr && cyc > rdy_cyc && cyc < rv_cyc);
      mem_rvalid = (cyc == rv_cyc) || (cyc < rdy_cyc);
      mem_rdata  = (cyc == rv_cyc) ? v.rdata : 16'hBEEF;
    end
    if (!got) begin
      fail_now($sformatf("v%0d done", n));
      sb_q.delete();
      req[v.core] = 1'b0;
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d quiet done", n), done, 4'b0);
    chk($sformatf("v%0d quiet wb_en", n), wb_en, 1'b0);
    chk($sformatf("v%0d quiet mem_valid", n), mem_valid, 1'b0);
  endtask

  task automatic run3(input logic [2:0] m, input logic [2:0] exp, input string nm);
    bit got;
    got  = 1'b0;
    req3 = m;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (done3 !== 3'b0) begin
        got = 1'b1;
        chk(nm, done3, exp);
        req3 = '0;
      end
      mem_ready3 = mem_valid3;
    end
    if (!got) begin
      fail_now(nm);
      req3 = '0;
    end
    mem_ready3 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   exp_q[$];
    int   ndone, ex;
    bit   pend;
    vec_t v;

    vt[0] = '{2, 1'b0, 16'h0010, 16'h0000, 0, 3, 16'h00AB, 4'b0100, 1'b1, 16'h00AB, 16'h0010, 5};
    vt[1] = '{0, 1'b1, 16'h0003, 16'h1234, 3, 0, 16'h0000, 4'b0001, 1'b0, 16'h00AB, 16'h0010, 5};
    vt[2] = '{1, 1'b0, 16'hFFFF, 16'h0000, 0, 1, 16'h5A5A, 4'b0010, 1'b1, 16'h5A5A, 16'hFFFF, 3};
    vt[3] = '{3, 1'b1, 16'h8000, 16'hFFFF, 0, 0, 16'h0000, 4'b1000, 1'b0, 16'h5A5A, 16'hFFFF, 2};
    vt[4] = '{3, 1'b0, 16'h0042, 16'h0000, 2, 2, 16'h0000, 4'b1000, 1'b1, 16'h0000, 16'h0042, 6};
    vt[5] = '{1, 1'b1, 16'h0001, 16'h0000, 1, 0, 16'h0000, 4'b0010, 1'b0, 16'h0000, 16'h0042, 3};

    // Reset state
    @(negedge clk);
    chk("rst done", done, 4'b0);
    chk("rst mem_valid", mem_valid, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, 16'h0);
    chk("rst mem_wdata", mem_wdata, 16'h0);
    chk("rst wb_en", wb_en, 1'b0);
    chk("rst wb_val", wb_val, 16'h0);
    chk("rst wb_ptr", wb_ptr, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      run_vec(v, i);
    end

    // Done masking: core 1 holds req one cycle past its done.
    req[1] = 1'b1; we[1] = 1'b1; addr[16 +: 16] = 16'h0055; wdata[16 +: 16] = 16'h0066;
    @(negedge clk);
    chk("mask c1 mem_valid", mem_valid, 1'b1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("mask c2 done", done, 4'b0010);
    chk("mask c2 mem_valid", mem_valid, 1'b0);
    @(negedge clk);
    chk("mask c3 no grant in done cycle", mem_valid, 1'b0);
    chk("mask c3 done", done, 4'b0);
    @(negedge clk);
    chk("mask c4 regrant", mem_valid, 1'b1);
    chk("mask c4 mem_addr", mem_addr, 16'h0055);
    req[1] = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("mask c5 done", done, 4'b0010);
    @(negedge clk);
    chk("mask c6 done", done, 4'b0);
    chk("mask c6 mem_valid", mem_valid, 1'b0);

    // Fairness: all four cores request continuously.
    do_reset();
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      addr[i*16 +: 16]  = 16'h0100 + 16'(i);
      wdata[i*16 +: 16] = 16'h2000 + 16'(i);
    end
    we = 4'b1010;
    req = 4'hF;
    ndone = 0;
    pend = 1'b0;
    for (int c = 0; c < 100 && ndone < 8; c++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        ex = exp_q.pop_front();
        chk($sformatf("fair grant %0d", ndone), done, 4'b0001 << ex);
        if (we[ex] == 1'b0) begin
          chk($sformatf("fair wb_val %0d", ndone), wb_val, (16'h0100 + 16'(ex)) ^ 16'hA5A5);
          chk($sformatf("fair wb_ptr %0d", ndone), wb_ptr, 16'h0100 + 16'(ex));
        end else begin
          chk($sformatf("fair wb_en %0d", ndone), wb_en, 1'b0);
        end
        ndone++;
      end
      mem_rvalid = pend;
      mem_rdata  = mem_addr ^ 16'hA5A5;
      pend       = mem_valid && !mem_we;
      mem_ready  = mem_valid;
    end
    chk("fair done count", ndone, 8);
    req = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset while waiting for read data.
    req[3] = 1'b1; we[3] = 1'b0; addr[48 +: 16] = 16'h7777;
    @(negedge clk);
    chk("rstw c1 mem_valid", mem_valid, 1'b1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rstw c2 mem_valid", mem_valid, 1'b0);
    rst_n = 1'b0;
    req[3] = 1'b0;
    #1;
    chk("rstw async mem_addr", mem_addr, 16'h0);
    chk("rstw async wb_val", wb_val, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = 16'h9999;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstw done %0d", c), done, 4'b0);
      chk($sformatf("rstw wb_en %0d", c), wb_en, 1'b0);
      chk($sformatf("rstw wb_val %0d", c), wb_val, 16'h0);
      chk($sformatf("rstw wb_ptr %0d", c), wb_ptr, 16'h0);
      chk($sformatf("rstw mem_valid %0d", c), mem_valid, 1'b0);
      chk($sformatf("rstw mem_addr %0d", c), mem_addr, 16'h0);
      chk($sformatf("rstw mem_we %0d", c), mem_we, 1'b0);
    end
    mem_rvalid = 1'b0;

    // Three cores: pointer wraps modulo 3.
    do_reset();
    run3(3'b010, 3'b010, "n3 core1 sets ptr 2");
    run3(3'b001, 3'b001, "n3 wrap to core0");
    run3(3'b101, 3'b100, "n3 ptr1 picks core2");
    run3(3'b011, 3'b001, "n3 ptr0 after core2");
    run3(3'b110, 3'b010, "n3 ptr1 picks core1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
